// File: rtl/instr_fetch_unit_pkg.sv
// Shared opcode/function constants and fetch-state encoding for the fetch stage.
// Imported by the top level and by anything that needs to decode jr.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  function automatic logic is_jr(input logic [5:0] op, input logic [5:0] func);
    return (op == OP_RTYPE) && (func == FUNC_JR);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_instr_mem.sv
// Instruction memory: synchronous write port for program loading and an
// asynchronous read port so the single-cycle datapath sees the word in the same cycle.
module instr_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: BOOT/RUN/HALT sequencing, PC register, next-PC selection,
// target fault detection and retired-instruction counter around the instruction memory.
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter int          IMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [31:0]        imem_wdata,
  input  logic               start,
  input  logic               stall,
  input  logic               Branch_eq,
  input  logic               Branch_ne,
  input  logic               Jump,
  input  logic               zero,
  input  logic [31:0]        rs_data,
  output logic [31:0]        instr,
  output logic [5:0]         op,
  output logic [5:0]         func,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [15:0]        imm16,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               fetch_valid,
  output logic               fault,
  output logic [31:0]        retired
);

  logic [1:0]  state_reg;
  logic [31:0] pc_reg;
  logic [31:0] retired_reg;
  logic        fault_reg;
  logic [31:0] mem_rdata;
  logic [31:0] next_pc;
  logic        taken;
  logic        bad_target;
  logic        run;

  assign run = (state_reg == ST_RUN);

  // Loading is only allowed before the program starts, so a running program cannot modify itself.
  instr_mem #(.AW(IMEM_AW)) u_imem (
    .clk   (clk),
    .we    (imem_we && (state_reg == ST_BOOT)),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (pc_reg[IMEM_AW+1:2]),
    .rdata (mem_rdata)
  );

  assign instr       = run ? mem_rdata : 32'h0;
  assign op          = instr[31:26];
  assign func        = instr[5:0];
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign imm16       = instr[15:0];
  assign pc          = pc_reg;
  assign pc_plus4    = pc_reg + 32'd4;
  assign fetch_valid = run;
  assign fault       = fault_reg;
  assign retired     = retired_reg;

  always_comb begin
    taken = (Branch_eq & zero) | (Branch_ne & ~zero);
    if (is_jr(op, func)) begin
      next_pc = rs_data;
    end else if (Jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (taken) begin
      next_pc = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    end else begin
      next_pc = pc_plus4;
    end
    // Any address bit above the IMEM word range means the target lies outside IMEM.
    bad_target = (next_pc[1:0] != 2'b00) || ((next_pc >> (IMEM_AW + 2)) != 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_BOOT;
      pc_reg      <= RESET_PC;
      retired_reg <= 32'd0;
      fault_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_BOOT: begin
          if (start) begin
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            retired_reg <= retired_reg + 32'd1;
            if (bad_target) begin
              state_reg <= ST_HALT;
              fault_reg <= 1'b1;
            end else begin
              pc_reg <= next_pc;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expectations are queued as stimulus is driven
// and popped when the corresponding DUT outputs are sampled one time unit after the edge.
module tb_instr_fetch_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          start, stall, Branch_eq, Branch_ne, Jump, zero;
  logic [31:0]   rs_data;
  logic [31:0]   instr, pc, pc_plus4, retired;
  logic [5:0]    op, func;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm16;
  logic          fetch_valid, fault;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] W0  = 32'h2001_0005;
  localparam logic [31:0] W1  = 32'h0043_0820;
  localparam logic [31:0] W2  = 32'h1000_FFFF;
  localparam logic [31:0] W3  = 32'h8C22_0004;
  localparam logic [31:0] W4  = 32'h0800_0040;
  localparam logic [31:0] W5  = 32'h1000_00FA;
  localparam logic [31:0] W8  = 32'h1400_0003;
  localparam logic [31:0] WJR = 32'h0060_0008;

  instr_fetch_unit #(.IMEM_AW(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .start(start), .stall(stall), .Branch_eq(Branch_eq),
    .Branch_ne(Branch_ne), .Jump(Jump), .zero(zero), .rs_data(rs_data),
    .instr(instr), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .fault(fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 0; Branch_eq = 0; Branch_ne = 0; Jump = 0; zero = 0; rs_data = 32'h0;
    imem_we = 0; start = 0;
  endtask

  task automatic load(input int idx, input logic [31:0] data);
    imem_we = 1; imem_waddr = AW'(idx); imem_wdata = data;
    tick();
    imem_we = 0;
  endtask

  // One clock edge with the currently driven controls, then check pc and retired.
  task automatic step(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_ret);
    expect_v(exp_pc);
    expect_v(exp_ret);
    tick();
    chk({tag, ".pc"}, pc);
    chk({tag, ".retired"}, retired);
  endtask

  task automatic check_now(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_v(e);
    chk(tag, obs);
  endtask

  initial begin
    rst_n = 0; imem_waddr = '0; imem_wdata = '0;
    clear_ctl();
    #2;
    check_now("rst.pc", pc, 32'h0);
    check_now("rst.retired", retired, 32'h0);
    check_now("rst.fault", 32'(fault), 32'h0);
    check_now("rst.valid", 32'(fetch_valid), 32'h0);
    check_now("rst.instr", instr, 32'h0);
    #1 rst_n = 1;

    load(0, W0); load(1, W1); load(2, W2); load(3, W3); load(4, W4);
    load(5, W5); load(8, W8); load(12, WJR); load(64, WJR);
    // Final load coincides with start: the write must land and the state must still advance.
    start = 1;
    load(9, WJR);
    start = 0;
    $display("boot: program loaded, start issued");
    check_now("boot.pc", pc, 32'h0);
    check_now("boot.valid", 32'(fetch_valid), 32'h1);

    // Sequential fetch
    check_now("seq0.instr", instr, W0);
    check_now("seq0.op", 32'(op), 32'h08);
    check_now("seq0.func", 32'(func), 32'h05);
    step("seq1", 32'h4, 32'd1);
    check_now("seq1.instr", instr, W1);
    check_now("seq1.func", 32'(func), 32'h20);
    check_now("seq1.rs", 32'(rs), 32'd2);
    check_now("seq1.rt", 32'(rt), 32'd3);
    check_now("seq1.rd", 32'(rd), 32'd1);
    step("seq2", 32'h8, 32'd2);
    check_now("seq2.instr", instr, W2);
    step("seq3", 32'hC, 32'd3);
    check_now("seq3.imm16", 32'(imm16), 32'h4);
    check_now("seq3.pc_plus4", pc_plus4, 32'h10);
    step("seq4", 32'h10, 32'd4);
    $display("sequential fetch 0,4,8,12 -> 16 done");

    // Jump and jr priority
    Jump = 1;
    step("jump", 32'h100, 32'd5);
    check_now("jump.instr", instr, WJR);
    rs_data = 32'h20;
    step("jr_over_jump", 32'h20, 32'd6);
    clear_ctl();
    Branch_ne = 1; zero = 0;
    step("bne_taken", 32'h30, 32'd7);
    clear_ctl();
    rs_data = 32'h8;
    step("jr_to_8", 32'h8, 32'd8);
    clear_ctl();
    Branch_eq = 1; zero = 1;
    step("beq_taken", 32'h8, 32'd9);
    zero = 0;
    step("beq_not", 32'hC, 32'd10);
    Branch_ne = 1; zero = 1;
    step("both_br", 32'h20, 32'd11);
    $display("jump/jr/branch checks done");

    // Stall with a taken branch pending and a RUN-time write attempt to word 0
    clear_ctl();
    stall = 1; Branch_ne = 1; imem_we = 1; imem_waddr = '0; imem_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step("stall", 32'h20, 32'd11);
    end
    clear_ctl();
    step("unstall", 32'h24, 32'd12);
    check_now("wr_start.instr", instr, WJR);
    $display("stall checks done");

    // Misaligned jr target faults
    rs_data = 32'h6;
    step("fault_jr", 32'h24, 32'd13);
    check_now("fault_jr.fault", 32'(fault), 32'h1);
    check_now("fault_jr.valid", 32'(fetch_valid), 32'h0);
    check_now("fault_jr.instr", instr, 32'h0);
    Jump = 1;
    step("halt_frozen", 32'h24, 32'd13);
    $display("misaligned jr fault checks done");

    // Asynchronous reset between clock edges
    clear_ctl();
    rst_n = 0;
    #1;
    check_now("arst.pc", pc, 32'h0);
    check_now("arst.valid", 32'(fetch_valid), 32'h0);
    check_now("arst.fault", 32'(fault), 32'h0);
    check_now("arst.retired", retired, 32'h0);
    #2 rst_n = 1;
    start = 1;
    tick();
    start = 0;
    check_now("rerun.instr", instr, W0);
    step("rerun1", 32'h4, 32'd1);
    step("rerun2", 32'h8, 32'd2);
    step("rerun3", 32'hC, 32'd3);
    step("rerun4", 32'h10, 32'd4);
    step("rerun5", 32'h14, 32'd5);
    $display("reset re-run from retained IMEM done");

    // Branch to 0x18 + 0x3E8 = 0x400, first address past IMEM
    Branch_eq = 1; zero = 1;
    step("fault_oob", 32'h14, 32'd6);
    check_now("fault_oob.fault", 32'(fault), 32'h1);
    $display("out-of-range branch fault checks done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
